pipelined_adder: RTL and testbench

//  Parametrised, pipelined carry-chained adder/subtractor; successor to the fixed 4-bit ripple adder.

---
 rtl/pipelined_adder_if.sv | 41 ++++
 rtl/pipelined_adder.sv | 152 +++++++++++++++
 tb/tb_pipelined_adder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The sat signal exists only when ADDER_SAT_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
`ifdef ADDER_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             zero;

`ifdef ADDER_SAT_EN
    modport master (
        output in_valid, a, b, ci, sub, sat, out_ready,
        input  in_ready, out_valid, sum, co, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, ci, sub, sat, out_ready,
        output in_ready, out_valid, sum, co, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf, zero
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined carry-chained adder/subtractor: one WIDTH/STAGES-bit slice per clock, global stall.
// Define ADDER_SAT_EN to add the per-operation sat input and signed saturation of the result.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L  = STAGES - 1;

    if ((WIDTH % STAGES) != 0 || STAGES < 1) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

`ifdef ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic neg);
        logic signed [WIDTH-1:0] lim;
        lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return lim;
    endfunction
`endif

    logic             advance;
    logic [WIDTH-1:0] bx_in;
    logic             cin_in;

    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_bx  [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES];
    logic             st_c   [STAGES];
    logic             st_vld [STAGES];
    logic [SW:0]      st_t   [STAGES];
    logic [WIDTH-1:0] st_ns  [STAGES];

    logic [WIDTH-1:0] a_p   [NI];
    logic [WIDTH-1:0] bx_p  [NI];
    logic [WIDTH-1:0] s_p   [NI];
    logic             cy_p  [NI];
    logic             vld_p [NI];
`ifdef ADDER_SAT_EN
    logic             st_sat [STAGES];
    logic             sat_p  [NI];
`endif

    logic [WIDTH-1:0] fin_raw;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_co;
    logic             fin_ovf;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ovf_q;
    logic             zero_q;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;
    assign bx_in        = bus.sub ? ~bus.b : bus.b;
    assign cin_in       = bus.sub | bus.ci;

    // Stage k: add slice k of a and b' with the carry handed over from stage k-1
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_a[k]   = bus.a;
            assign st_bx[k]  = bx_in;
            assign st_s[k]   = '0;
            assign st_c[k]   = cin_in;
            assign st_vld[k] = bus.in_valid;
`ifdef ADDER_SAT_EN
            assign st_sat[k] = bus.sat;
`endif
        end else begin : g_body
            assign st_a[k]   = a_p[k-1];
            assign st_bx[k]  = bx_p[k-1];
            assign st_s[k]   = s_p[k-1];
            assign st_c[k]   = cy_p[k-1];
            assign st_vld[k] = vld_p[k-1];
`ifdef ADDER_SAT_EN
            assign st_sat[k] = sat_p[k-1];
`endif
        end
        assign st_t[k]  = {1'b0, st_a[k][k*SW +: SW]} + {1'b0, st_bx[k][k*SW +: SW]}
                        + (SW+1)'(st_c[k]);
        assign st_ns[k] = st_s[k] | (WIDTH'(st_t[k][SW-1:0]) << (k*SW));
    end

    // Skew/de-skew registers between stages; data is not reset, only the valid chain
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k]  <= st_a[k];
                bx_p[k] <= st_bx[k];
                s_p[k]  <= st_ns[k];
                cy_p[k] <= st_t[k][SW];
`ifdef ADDER_SAT_EN
                sat_p[k] <= st_sat[k];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                vld_p[k] <= st_vld[k];
            end
        end
    end

    // Final slice: flags come from the MSB slice, saturation applies before the zero test
    assign fin_raw = st_ns[L];
    assign fin_co  = st_t[L][SW];
    assign fin_ovf = (st_a[L][WIDTH-1] == st_bx[L][WIDTH-1]) &&
                     (fin_raw[WIDTH-1] != st_a[L][WIDTH-1]);
`ifdef ADDER_SAT_EN
    assign fin_sum = (st_sat[L] && fin_ovf) ? saturate(st_a[L][WIDTH-1]) : fin_raw;
`else
    assign fin_sum = fin_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= st_vld[L];
            if (st_vld[L]) begin
                sum_q  <= fin_sum;
                co_q   <= fin_co;
                ovf_q  <= fin_ovf;
                zero_q <= (fin_sum == '0);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table plus randomized traffic against an arithmetic model.
// Saturation vectors are included when ADDER_SAT_EN is defined.
module tb_pipelined_adder;
    localparam int W  = 32;
    localparam int ST = 4;
`ifdef ADDER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W-1));
    localparam longint UMAX = (longint'(1) <<< W) - 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic         sat;
        res_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cur_sat;
    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();
    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub, input logic sat);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        bus.sub      = sub;
        cur_sat      = sat;
`ifdef ADDER_SAT_EN
        bus.sat      = sat;
`endif
    endtask

    // Reference: true signed/unsigned results with wide integers, then reduced to W bits
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub, input logic sat);
        longint sa, sb, ua, ub, res;
        res_t   r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            res  = sa - sb;
            r.co = (ua >= ub);
        end else begin
            res  = sa + sb + longint'(ci);
            r.co = (ua + ub + longint'(ci)) > UMAX;
        end
        r.ovf = (res > SMAX) || (res < SMIN);
        r.sum = W'(res);
        if (SAT_EN && sat && r.ovf) r.sum = W'((res > 0) ? SMAX : SMIN);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                input logic sub, input logic sat, input logic [W-1:0] s,
                                input logic co, input logic ovf, input logic zero);
        vec_t v;
        v.a = a; v.b = b; v.ci = ci; v.sub = sub; v.sat = sat;
        v.exp.sum = s; v.exp.co = co; v.exp.ovf = ovf; v.exp.zero = zero;
        return v;
    endfunction

    // One clock: sample at negedge, score outputs against the model queue, record acceptance
    task automatic cycle(output bit acc, output bit got);
        res_t e;
        acc = 1'b0;
        got = 1'b0;
        @(negedge clk);
        check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q[0];
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    got = 1'b1;
                end
                check("sum", bus.sum, e.sum);
                check("co", bus.co, e.co);
                check("ovf", bus.ovf, e.ovf);
                check("zero", bus.zero, e.zero);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub, cur_sat));
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[$];
        vec_t         v;
        int           lat, k, cyc, nout;
        bit           acc, got;
        logic [W-1:0] corner [4];
        logic [W-1:0] ra, rb;

        corner[0] = '0; corner[1] = '1; corner[2] = 32'h7FFF_FFFF; corner[3] = 32'h8000_0000;

        vecs.push_back(mk(32'h0000_FFFF, 32'h1, 0, 0, 0, 32'h0001_0000, 0, 0, 0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0, 1, 0, 0, 32'h0, 1, 0, 1));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h1, 0, 0, 0, 32'h8000_0000, 0, 1, 0));
        vecs.push_back(mk(32'h5, 32'h7, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0));
        vecs.push_back(mk(32'h7, 32'h5, 0, 1, 0, 32'h2, 1, 0, 0));
        vecs.push_back(mk(32'h8000_0000, 32'h1, 0, 1, 0, 32'h7FFF_FFFF, 1, 1, 0));
        vecs.push_back(mk(32'h5, 32'h5, 1, 1, 0, 32'h0, 1, 0, 1));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 0));
        vecs.push_back(mk(32'h0, 32'hFFFF_FFFF, 1, 0, 0, 32'h0, 1, 0, 1));
`ifdef ADDER_SAT_EN
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h1, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0));
        vecs.push_back(mk(32'h8000_0000, 32'h1, 0, 1, 1, 32'h8000_0000, 1, 1, 0));
        vecs.push_back(mk(32'h1, 32'h2, 0, 0, 1, 32'h3, 0, 0, 0));
`endif

        // Reset held with in_valid asserted
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1, 32'h1234, 32'h1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_co", bus.co, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_zero", bus.zero, 0);
        rst_n = 1'b1;
        drive(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed table: single operations, latency and flags
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(1, v.a, v.b, v.ci, v.sub, v.sat);
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            @(posedge clk);
            #1;
            drive(0, '0, '0, 0, 0, 0);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!bus.out_valid && lat < 20);
            check($sformatf("v%0d_latency", i), lat, ST);
            check($sformatf("v%0d_sum", i), bus.sum, v.exp.sum);
            check($sformatf("v%0d_co", i), bus.co, v.exp.co);
            check($sformatf("v%0d_ovf", i), bus.ovf, v.exp.ovf);
            check($sformatf("v%0d_zero", i), bus.zero, v.exp.zero);
            @(posedge clk);
            #1;
        end

        // Back-to-back ops with differing sub/ci must not mix
        drive(1, 32'h5, 32'h7, 1, 1, 0);          cycle(acc, got);
        drive(1, 32'h5, 32'h7, 1, 0, 0);          cycle(acc, got);
        drive(1, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);  cycle(acc, got);
        drive(1, 32'h3, 32'h3, 0, 1, 0);          cycle(acc, got);
        drive(1, 32'h1234_5678, 32'h0FED_CBA9, 0, 1, 0); cycle(acc, got);
        drive(0, '0, '0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            cycle(acc, got);
            k++;
        end
        check("b2b_drained", exp_q.size(), 0);

        // Backpressure: 16 ops a=k, b=k/2 with a 3-cycle consumer stall mid-stream
        k = 0; cyc = 0; nout = 0;
        while ((k < 16 || exp_q.size() != 0) && cyc < 200) begin
            bus.out_ready = !(cyc >= 8 && cyc < 11);
            if (k < 16) drive(1, W'(k), W'(k / 2), 0, 0, 0);
            else        drive(0, '0, '0, 0, 0, 0);
            cycle(acc, got);
            if (acc) k++;
            if (got) nout++;
            cyc++;
        end
        check("bp_accepted", k, 16);
        check("bp_delivered", nout, 16);
        check("bp_queue_empty", exp_q.size(), 0);
        bus.out_ready = 1'b1;
        drive(0, '0, '0, 0, 0, 0);

        // Reset while operations are in flight: none of them may emerge
        drive(1, 32'd100, 32'd23, 0, 0, 0); cycle(acc, got);
        drive(1, 32'd7, 32'd9, 0, 0, 0);    cycle(acc, got);
        drive(0, '0, '0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("flush_out_valid_%0d", i), bus.out_valid, 0);
            @(posedge clk);
            #1;
        end

        // Randomized traffic with random backpressure and corner operands
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 4) != 0), ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
            cycle(acc, got);
        end
        bus.out_ready = 1'b1;
        drive(0, '0, '0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            cycle(acc, got);
            k++;
        end
        check("rand_drained", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) cycle(acc, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
